// File: rtl/wb_initiator_if.sv
// Command, write-data, response and Wishbone signals for wb_initiator.
// master = the initiator's view; slave = the command source, response sink and bus target.
interface wb_initiator_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [3:0]  cmd_sel;
  logic [3:0]  cmd_len;
  logic        wdat_valid;
  logic        wdat_ready;
  logic [31:0] wdat;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_last;
  logic        rsp_err;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack_i;
  logic        wbm_err_i;
  logic [31:0] wbm_dat_i;

  modport master (
    input  cmd_valid, cmd_we, cmd_adr, cmd_sel, cmd_len,
    input  wdat_valid, wdat, rsp_ready,
    input  wbm_ack_i, wbm_err_i, wbm_dat_i,
    output cmd_ready, wdat_ready,
    output rsp_valid, rsp_dat, rsp_last, rsp_err,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_adr, cmd_sel, cmd_len,
    output wdat_valid, wdat, rsp_ready,
    output wbm_ack_i, wbm_err_i, wbm_dat_i,
    input  cmd_ready, wdat_ready,
    input  rsp_valid, rsp_dat, rsp_last, rsp_err,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );
endinterface

// File: rtl/wb_initiator.sv
// Wishbone B3 classic initiator: turns valid/ready commands into single or incrementing
// bursts, returns read data / completion on a one-entry response register, aborts stalled beats.
module wb_initiator #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic          wb_clk_i,
  input logic          wb_rstn_i,
  wb_initiator_if.master bus
);
  localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, PREP, BUS} state_e;

  state_e        state_q;
  logic          we_q;
  logic [3:0]    sel_q;
  logic [3:0]    len_q;
  logic [3:0]    beat_q;
  logic [31:0]   adr_q;
  logic [31:0]   dat_q;
  logic          cyc_q;
  logic          stb_q;
  logic [TW-1:0] tmo_q;
  logic          rsp_valid_q;
  logic          rsp_last_q;
  logic          rsp_err_q;
  logic [31:0]   rsp_dat_q;

  logic          last_beat_d;
  logic          expired_d;
  logic          prep_go_d;

  assign last_beat_d = (beat_q == len_q);
  // With TIMEOUT=0 the counter still runs but can never expire.
  assign expired_d   = (TIMEOUT != 0) && (tmo_q == TW'(TIMEOUT - 1));
  // A new beat may only start once the previous response has been drained.
  assign prep_go_d   = !rsp_valid_q && (!we_q || bus.wdat_valid);

  assign bus.cmd_ready  = wb_rstn_i && (state_q == IDLE);
  assign bus.wdat_ready = wb_rstn_i && (state_q == PREP) && we_q && !rsp_valid_q;

  assign bus.wbm_cyc_o = cyc_q;
  assign bus.wbm_stb_o = stb_q;
  assign bus.wbm_we_o  = we_q;
  assign bus.wbm_sel_o = sel_q;
  assign bus.wbm_adr_o = adr_q;
  assign bus.wbm_dat_o = dat_q;

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_dat   = rsp_dat_q;
  assign bus.rsp_last  = rsp_last_q;
  assign bus.rsp_err   = rsp_err_q;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rstn_i) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      sel_q       <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      tmo_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_dat_q   <= '0;
    end else begin
      if (rsp_valid_q && bus.rsp_ready) rsp_valid_q <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (bus.cmd_valid) begin
            we_q    <= bus.cmd_we;
            sel_q   <= bus.cmd_sel;
            len_q   <= bus.cmd_len;
            adr_q   <= bus.cmd_adr;
            beat_q  <= '0;
            cyc_q   <= 1'b1;
            state_q <= PREP;
          end
        end
        PREP: begin
          if (prep_go_d) begin
            if (we_q) dat_q <= bus.wdat;
            stb_q   <= 1'b1;
            tmo_q   <= '0;
            state_q <= BUS;
          end
        end
        BUS: begin
          if (bus.wbm_ack_i) begin
            // Writes only report once, on the final beat.
            if (!we_q || last_beat_d) begin
              rsp_valid_q <= 1'b1;
              rsp_dat_q   <= we_q ? 32'h0 : bus.wbm_dat_i;
              rsp_last_q  <= last_beat_d;
              rsp_err_q   <= 1'b0;
            end
            stb_q <= 1'b0;
            if (last_beat_d) begin
              cyc_q   <= 1'b0;
              state_q <= IDLE;
            end else begin
              adr_q   <= adr_q + 32'd4;
              beat_q  <= beat_q + 4'd1;
              state_q <= PREP;
            end
          end else if (bus.wbm_err_i || expired_d) begin
            rsp_valid_q <= 1'b1;
            rsp_dat_q   <= '0;
            rsp_last_q  <= 1'b1;
            rsp_err_q   <= 1'b1;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            state_q     <= IDLE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/wb_initiator.md
# wb_initiator

Wishbone classic (B3, non-pipelined) initiator that turns a valid/ready command stream into single or incrementing-burst bus cycles on a 32-bit Wishbone slave port. It sits in the user area between a command source (LA probes or a local sequencer) and a user-side Wishbone target such as the counter slave, returning read data and completion status on a response stream. It also enforces a per-beat acknowledge timeout so a dead slave cannot hang the bus.

## Interface
- TIMEOUT, 255, cycles stb_o may stay high without ack/err before abort; 0 disables timeout
- wb_clk_i  in  1  clock, all logic on rising edge
- wb_rstn_i  in  1  synchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_we  in  1  1 = write burst, 0 = read burst
- cmd_adr  in  32  start byte address
- cmd_sel  in  4  byte select, used for every beat
- cmd_len  in  4  beats minus one (0..15 → 1..16 beats)
- wdat_valid  in  1  write data offered
- wdat_ready  out  1  write data consumed when both high
- wdat  in  32  write data for the next write beat
- rsp_valid  out  1  response register full
- rsp_ready  in  1  response consumer ready
- rsp_dat  out  32  read data; 0 for write/error responses
- rsp_last  out  1  final response of the command
- rsp_err  out  1  command terminated by wbm_err_i or timeout
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  Wishbone cycle/strobe/write
- wbm_sel_o  out  4  byte select
- wbm_adr_o  out  32  address
- wbm_dat_o  out  32  write data
- wbm_ack_i, wbm_err_i  in  1 each  slave acknowledge / error
- wbm_dat_i  in  32  read data

## Operation
- States: IDLE, PREP, BUS. All outputs registered except cmd_ready and wdat_ready (decoded from state).
- IDLE: cmd_ready=1. On accept: latch we, sel, len, adr; beat=0; wbm_cyc_o←1; → PREP.
- PREP (cyc=1, stb=0): proceeds only if response register empty (rsp_valid=0).
  - Write: wdat_ready=1 when rsp empty; on wdat handshake wbm_dat_o←wdat, stb←1, → BUS. No wdat: stay.
  - Read: stb←1, → BUS.
- BUS (cyc=1, stb=1): hold adr/dat/sel/we stable until ack, err or timeout.
  - ack, read: rsp_dat←wbm_dat_i, rsp_valid←1, rsp_err←0, rsp_last←(beat==len).
  - ack, write: response only on last beat (rsp_dat=0, last=1, err=0).
  - ack, not last: adr_o←adr_o+4 (mod 2^32), beat←beat+1, stb←0, → PREP.
  - ack, last: cyc←0, stb←0, → IDLE.
  - err_i (ack low): rsp_valid←1, err=1, last=1, rsp_dat=0; cyc,stb←0; → IDLE. Remaining beats dropped; unconsumed write data stays in the source.
  - Timeout: counter cleared on BUS entry, increments each BUS cycle; when TIMEOUT cycles elapse with no ack/err, same as err_i.
  - ack and err in same cycle: ack wins. ack on the expiry cycle: ack wins.
- Response register: cleared when rsp_valid && rsp_ready; single entry; never overwritten (PREP gating guarantees this).
- Reset (wb_rstn_i=0 at an edge): state IDLE, beat/timeout counters 0, all bus outputs 0, rsp_valid/last/err 0, rsp_dat 0; cmd_ready/wdat_ready 0 while reset asserted. Reset mid-burst drops cyc/stb at that edge, emits no response.

## Timing
- Accept at edge N: cyc_o high from N; stb_o high from N+1 at earliest (read, rsp empty).
- Beat: stb rises one cycle after entering PREP; ack sampled at the edge it is high; minimum 2 cycles/beat.
- rsp_valid rises at the edge that samples ack/err/timeout.
- Timeout: with ack never returned, stb_o high exactly TIMEOUT cycles, then cyc/stb low and rsp_err=1 next cycle.
- cyc_o stays high continuously across all beats of one burst, including PREP stalls.
- New command accepted no earlier than the cycle after cyc_o falls.

## Test plan
- Single read, len=0, adr=0x3000_0000, slave acks 1 cycle after stb with 0x0000_0066 → one response dat=0x66, last=1, err=0; cyc high exactly 2 cycles.
- Write burst len=2 from 0x3000_0010, wdat 0xA,0xB,0xC with 3-cycle gap before 0xB → bus writes at 0x10,0x14,0x18 with matching data; cyc stays high through gap; one response last=1, err=0.
- Read burst len=3, rsp_ready low 5 cycles after first response → stb held low in PREP until drained; 4 responses, last only on 4th, addresses +4 each.
- TIMEOUT=8, slave never acks → stb high 8 cycles, then cyc/stb=0, response err=1, last=1, dat=0; cmd_ready=1 next cycle.
- Read burst len=1 at 0xFFFF_FFFC, second beat answered with wbm_err_i → first response ok, second err=1 last=1, wbm_adr_o on beat 2 = 0x0000_0000.
- Reset asserted during BUS of a 4-beat write → cyc/stb/rsp_valid 0 at that edge, no response, wdat_ready 0; after release cmd_ready=1.
